sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-in, parallel-out deserialiser that sits directly upstream of the team's N-bit PIPO register.
- Accepts one qualified serial bit per cycle and assembles N-bit words.
- Presents each completed word on a valid/ready parallel port; the PIPO's load enable consumes it.
- Has a separate output holding register, so the next word can assemble while the current word waits for acceptance.

Parameters:
- N, 8, word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = first received bit lands in pout[N-1]; 0 = first received bit lands in pout[0].
- CW, $clog2(N), derived localparam; bit counter width.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- res  in  1  reset, synchronous and active-high.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin carries a bit this cycle.
- sin_ready  out  1  block can accept a bit this cycle; a bit is accepted when sin_valid & sin_ready.
- pout  out  N  assembled parallel word (output holding register).
- pout_valid  out  1  pout holds an unconsumed word.
- pout_ready  in  1  downstream (PIPO load) accepts pout this cycle.
- bit_cnt  out  CW  bits accepted into the current partial word.

Behaviour:
Reset:
- res high at a rising edge forces: state=FILL, shift register=0, bit_cnt=0, pout=0, pout_valid=0.
- Reset dominates every other event in the same cycle. A bit presented during a reset cycle is discarded.

State machine (typedef deser_state_t):
- FILL: sin_ready=1.
  - Each accepted bit shifts into the shift register (direction set by MSB_FIRST) and increments bit_cnt.
  - Nth bit accepted (bit_cnt==N-1 and accept), with the output register free (pout_valid==0) or draining this cycle (pout_valid & pout_ready):
    - pout <= completed word, including the bit arriving this cycle.
    - pout_valid <= 1; bit_cnt <= 0; stay in FILL.
  - Nth bit accepted while the output register is occupied and not draining:
    - Shift register holds the full word; bit_cnt <= 0; go to STALL.
- STALL: sin_ready=0; shift register frozen.
  - On pout_valid & pout_ready: pout <= shift-register word, pout_valid stays 1, go to FILL.

Output handshake:
- Latency: word visible with pout_valid=1 in the cycle immediately after the edge that accepted its Nth bit.
- pout_valid & pout_ready with no new word loading: pout_valid <= 0 next cycle; pout keeps its last value.
- While pout_valid=1 and pout_ready=0, pout is stable.

Boundary conditions:
- sin_valid gaps: shift register and bit_cnt hold; gaps anywhere inside a word are legal.
- Continuous sin_valid with pout_ready=1 gives one word every N cycles; sin_ready never drops.
- Maximum buffering is two words: one in pout, one in the shift register (STALL).
- Reset mid-word discards the partial word.
- Reset while in STALL discards both buffered words.
- No wrap-around of bit_cnt beyond N-1.

Decomposition:
- Package deser_pkg holds: deser_state_t (FILL, STALL), a N_MAX=64 constant, and a helper function that inserts a bit by direction.
- One sub-module: shift_reg_n (N-bit shift register with enable, direction parameter and synchronous active-high clear).
- FSM, bit_cnt and the output register stay in sipo_deser.

Test Plan (N=8):
1. Reset: res=1 for 2 cycles with sin_valid=1 -> pout=8'h00, pout_valid=0, bit_cnt=0, sin_ready=1; no bits captured.
2. Bit order, MSB_FIRST=1, pout_ready=1: send 1,0,1,0,0,1,0,1 -> pout=8'hA5 with pout_valid=1 one cycle after the 8th bit, then pout_valid=0. Send 1,0,0,0,0,0,0,0 -> 8'h80. Repeat the second sequence with MSB_FIRST=0 -> 8'h01.
3. Back-to-back: 16 consecutive bits forming 8'h3C then 8'hC3, pout_ready=1 -> pout_valid pulses at cycles 9 and 17 with 8'h3C and 8'hC3; sin_ready=1 throughout.
4. Backpressure: pout_ready=0, send 8'h0F then 8'hF0 ->
   - pout=8'h0F is held stable.
   - sin_ready=0 after the 16th bit; state=STALL.
   - Raise pout_ready for 1 cycle -> next cycle pout=8'hF0, pout_valid=1, sin_ready=1.
5. Gaps: 8'h96 sent with sin_valid low for 1-3 idle cycles between bits -> bit_cnt freezes during gaps; pout=8'h96.
6. Reset mid-operation:
   - Reset after 5 bits -> bit_cnt=0; the next 8 bits form a clean 8'h5A.
   - Reset in STALL -> pout_valid=0, pout=8'h00, sin_ready=1.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-in, parallel-out deserialiser.
package deser_pkg;

   localparam int unsigned N_MAX = 64;

   typedef logic [0:0] deser_state_t;
   localparam deser_state_t FILL  = 1'b0;
   localparam deser_state_t STALL = 1'b1;

   // MSB-first shifts toward the top so the first bit ends in bit n-1;
   // LSB-first enters at bit n-1 and walks down so the first bit ends in bit 0.
   function automatic logic [N_MAX-1:0] insert_bit(
      input logic [N_MAX-1:0] word,
      input logic             b,
      input logic             msb_first,
      input int unsigned      n
   );
      logic [N_MAX-1:0] r;
      if (msb_first) begin
         r = {word[N_MAX-2:0], b};
      end else begin
         r        = word >> 1;
         r[n-1]   = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_reg_n.sv
// N-bit shift register with enable, direction select and synchronous clear.
module shift_reg_n
   import deser_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic         CLK,
   input  logic         clr,
   input  logic         en,
   input  logic         din,
   output logic [N-1:0] q,
   output logic [N-1:0] nxt
);

   // nxt is the word as it will look once din is shifted in this cycle.
   always_comb begin
      nxt = N'(insert_bit(N_MAX'(q), din, MSB_FIRST, N));
   end

   always_ff @(posedge CLK) begin
      if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserialiser with a separate output holding register.
module sipo_deser
   import deser_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b1,
   localparam int unsigned CW       = $clog2(N)
) (
   input  logic          CLK,
   input  logic          res,
   input  logic          sin,
   input  logic          sin_valid,
   output logic          sin_ready,
   output logic [N-1:0]  pout,
   output logic          pout_valid,
   input  logic          pout_ready,
   output logic [CW-1:0] bit_cnt
);

   deser_state_t state;
   logic [N-1:0] sr_q;
   logic [N-1:0] sr_nxt;
   logic         accept;
   logic         last;
   logic         drain;

   assign sin_ready = (state == FILL);
   assign accept    = sin_valid & sin_ready;
   assign last      = (bit_cnt == CW'(N-1));
   assign drain     = pout_valid & pout_ready;

   shift_reg_n #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .CLK (CLK),
      .clr (res),
      .en  (accept),
      .din (sin),
      .q   (sr_q),
      .nxt (sr_nxt)
   );

   always_ff @(posedge CLK) begin
      if (res) begin
         state      <= FILL;
         bit_cnt    <= '0;
         pout       <= '0;
         pout_valid <= 1'b0;
      end else begin
         // A drain clears valid unless a new word loads in the same cycle.
         if (drain) begin
            pout_valid <= 1'b0;
         end
         case (state)
            FILL: begin
               if (accept) begin
                  if (last) begin
                     bit_cnt <= '0;
                     if (!pout_valid || pout_ready) begin
                        pout       <= sr_nxt;
                        pout_valid <= 1'b1;
                     end else begin
                        state <= STALL;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
            end
            STALL: begin
               if (drain) begin
                  pout       <= sr_q;
                  pout_valid <= 1'b1;
                  state      <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (N=8, both bit orders).
module tb_sipo_deser;

   logic       CLK = 1'b0;
   logic       res;
   logic       sin;
   logic       sin_valid;
   logic       pout_ready;
   logic       sin_ready,   sin_ready_l;
   logic [7:0] pout,        pout_l;
   logic       pout_valid,  pout_valid_l;
   logic [2:0] bit_cnt,     bit_cnt_l;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 CLK = ~CLK;

   sipo_deser #(.N(8), .MSB_FIRST(1'b1)) dut (
      .CLK(CLK), .res(res), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready),
      .pout(pout), .pout_valid(pout_valid), .pout_ready(pout_ready), .bit_cnt(bit_cnt)
   );

   sipo_deser #(.N(8), .MSB_FIRST(1'b0)) dut_l (
      .CLK(CLK), .res(res), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready_l),
      .pout(pout_l), .pout_valid(pout_valid_l), .pout_ready(pout_ready), .bit_cnt(bit_cnt_l)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Sends w starting with bit 7; checks sin_ready after every bit but the last.
   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) begin
         sin       = w[i];
         sin_valid = 1'b1;
         tick();
         if (i != 0) check("sin_ready_in_word", 64'(sin_ready), 64'd1);
      end
      sin_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] pair;
      logic [7:0]  gw;

      // 1. reset with bits offered
      res = 1'b1; sin = 1'b1; sin_valid = 1'b1; pout_ready = 1'b1;
      tick(); tick();
      res = 1'b0; sin_valid = 1'b0;
      check("rst_pout",       64'(pout),       64'h00);
      check("rst_pout_valid", 64'(pout_valid), 64'd0);
      check("rst_bit_cnt",    64'(bit_cnt),    64'd0);
      check("rst_sin_ready",  64'(sin_ready),  64'd1);

      // 2. bit order
      send_word(8'hA5);
      check("a5_valid", 64'(pout_valid), 64'd1);
      check("a5_pout",  64'(pout),       64'hA5);
      tick();
      check("a5_drained", 64'(pout_valid), 64'd0);
      check("a5_kept",    64'(pout),       64'hA5);
      send_word(8'h80);
      check("msb80_pout",  64'(pout),         64'h80);
      check("lsb01_pout",  64'(pout_l),       64'h01);
      check("lsb01_valid", 64'(pout_valid_l), 64'd1);
      tick();

      // 3. back-to-back words
      pair = 16'h3CC3;
      for (int i = 15; i >= 0; i--) begin
         sin = pair[i]; sin_valid = 1'b1;
         tick();
         check("b2b_sin_ready", 64'(sin_ready), 64'd1);
         if (i == 8) begin
            check("b2b_w0_valid", 64'(pout_valid), 64'd1);
            check("b2b_w0",       64'(pout),       64'h3C);
         end
         if (i == 7) check("b2b_gap_valid", 64'(pout_valid), 64'd0);
         if (i == 0) begin
            check("b2b_w1_valid", 64'(pout_valid), 64'd1);
            check("b2b_w1",       64'(pout),       64'hC3);
         end
      end
      sin_valid = 1'b0;
      tick();

      // 4. backpressure into STALL
      pout_ready = 1'b0;
      send_word(8'h0F);
      check("bp_w0_valid", 64'(pout_valid), 64'd1);
      check("bp_w0",       64'(pout),       64'h0F);
      for (int i = 7; i >= 0; i--) begin
         sin = gw[0]; gw = 8'hF0; sin = gw[i]; sin_valid = 1'b1;
         tick();
         check("bp_pout_stable", 64'(pout), 64'h0F);
      end
      sin_valid = 1'b0;
      check("bp_stall_ready", 64'(sin_ready), 64'd0);
      check("bp_stall_cnt",   64'(bit_cnt),   64'd0);
      tick();
      check("bp_stall_hold", 64'(sin_ready), 64'd0);
      check("bp_hold_pout",  64'(pout),      64'h0F);
      pout_ready = 1'b1;
      tick();
      pout_ready = 1'b0;
      check("bp_w1",       64'(pout),       64'hF0);
      check("bp_w1_valid", 64'(pout_valid), 64'd1);
      check("bp_w1_ready", 64'(sin_ready),  64'd1);
      pout_ready = 1'b1;
      tick();
      check("bp_drained", 64'(pout_valid), 64'd0);

      // 5. idle gaps between bits
      gw = 8'h96;
      for (int i = 7; i >= 0; i--) begin
         sin = gw[i]; sin_valid = 1'b1;
         tick();
         sin_valid = 1'b0;
         if (i != 0) begin
            for (int g = 0; g < 1 + (i % 3); g++) begin
               tick();
               check("gap_cnt_frozen", 64'(bit_cnt), 64'(8 - i));
            end
         end
      end
      check("gap_pout",  64'(pout),       64'h96);
      check("gap_valid", 64'(pout_valid), 64'd1);
      tick();

      // 6a. reset mid-word
      for (int i = 0; i < 5; i++) begin
         sin = 1'b1; sin_valid = 1'b1;
         tick();
      end
      sin_valid = 1'b0;
      check("mid_cnt5", 64'(bit_cnt), 64'd5);
      res = 1'b1;
      tick();
      res = 1'b0;
      check("mid_rst_cnt", 64'(bit_cnt), 64'd0);
      send_word(8'h5A);
      check("mid_clean_word", 64'(pout),       64'h5A);
      check("mid_clean_valid", 64'(pout_valid), 64'd1);
      tick();

      // 6b. reset while in STALL
      pout_ready = 1'b0;
      send_word(8'h11);
      send_word(8'h22);
      check("stall_before_rst", 64'(sin_ready), 64'd0);
      res = 1'b1;
      tick();
      res = 1'b0;
      check("stall_rst_valid", 64'(pout_valid), 64'd0);
      check("stall_rst_pout",  64'(pout),       64'h00);
      check("stall_rst_ready", 64'(sin_ready),  64'd1);
      check("stall_rst_cnt",   64'(bit_cnt),    64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
